parking_zone_ctrl: RTL and testbench

- Parametrised multi-zone parking occupancy controller, generalising the two-zone (university/public) manager to NUM_ZONES zones.
- Each zone's capacity follows an hourly schedule driven by an external hour counter (TimeHandler).
- One entry/exit event per cycle is accepted or rejected against the zone's live capacity.
- Over-capacity after a schedule change is tracked, not truncated: parked cars are never deleted.

---
 rtl/parking_pkg.sv | 35 +++
 rtl/parking_zone_slot.sv | 112 +++++++++++
 rtl/parking_zone_ctrl.sv | 114 +++++++++++
 tb/tb_parking_zone_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types, constants and saturating arithmetic helpers for the parking zone controller.
package parking_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam logic DIR_ENTER = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

    // Zone select width, never narrower than one bit.
    function automatic int zone_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Adds a signed step to an unsigned value, clamping to [0, max_val].
    function automatic int unsigned sat_add_step(input int unsigned val, input int step,
                                                 input int unsigned max_val);
        longint sum_l;
        sum_l = longint'(val) + longint'(step);
        if (sum_l < 64'sd0) begin
            return 32'd0;
        end else if (sum_l > longint'(max_val)) begin
            return max_val;
        end else begin
            return sum_l[31:0];
        end
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sat_dec16(input logic [15:0] v);
        return (v == 16'h0000) ? v : v - 16'd1;
    endfunction

endpackage

// File: rtl/parking_zone_slot.sv
// One parking zone: hourly capacity schedule, occupancy counter and event judgement.
module parking_zone_slot
    import parking_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int HOUR_W     = 5,
    parameter int OPEN_HOUR  = 8,
    parameter int RAMP_START = 13,
    parameter int RAMP_END   = 16,
    parameter logic [CNT_W-1:0] CAP_DAY   = CNT_W'(500),
    parameter logic [CNT_W-1:0] CAP_NIGHT = CNT_W'(200),
    parameter logic [CNT_W-1:0] CAP_STEP  = CNT_W'(0)
) (
    input  logic              clk,
    input  logic              start,
    input  logic              tick,
    input  logic [HOUR_W-1:0] hour,
    input  logic              ev_hit,
    input  logic              ev_enter,
    output logic [CNT_W-1:0]  cap,
    output logic [CNT_W-1:0]  occ,
    output logic [CNT_W-1:0]  free,
    output logic              has_space,
    output logic              over_cap,
    output logic              overflow,
    output logic              ev_acc,
    output logic              ev_rej
);

    localparam logic [HOUR_W-1:0] OPEN_H  = HOUR_W'(OPEN_HOUR);
    localparam logic [HOUR_W-1:0] RAMP_S  = HOUR_W'(RAMP_START);
    localparam logic [HOUR_W-1:0] RAMP_E  = HOUR_W'(RAMP_END);
    localparam int                STEP_I  = int'($signed(CAP_STEP));
    localparam int unsigned       MAX_I   = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO    = CNT_W'(0);

    logic [CNT_W-1:0] cap_next_s;
    logic [CNT_W-1:0] occ_next_s;
    logic [CNT_W-1:0] free_next_s;
    logic             over_next_s;

    // Capacity for the coming cycle: only the new hour's rule applies, no catch-up.
    always_comb begin
        cap_next_s = cap;
        if (!tick) begin
            cap_next_s = cap;
        end else if (hour == OPEN_H) begin
            cap_next_s = CAP_DAY;
        end else if ((hour >= RAMP_S) && (hour < RAMP_E)) begin
            cap_next_s = CNT_W'(sat_add_step(32'(cap), STEP_I, MAX_I));
        end else if (hour == RAMP_E) begin
            cap_next_s = CAP_NIGHT;
        end else begin
            cap_next_s = cap;
        end
    end

    // Event judgement against the post-update capacity; exits are never blocked by over-capacity.
    always_comb begin
        occ_next_s = occ;
        ev_acc     = 1'b0;
        ev_rej     = 1'b0;
        if (!ev_hit) begin
            occ_next_s = occ;
        end else if (ev_enter == DIR_ENTER) begin
            if (occ >= cap_next_s) begin
                ev_rej = 1'b1;
            end else begin
                occ_next_s = occ + ONE;
                ev_acc     = 1'b1;
            end
        end else begin
            if (occ == ZERO) begin
                ev_rej = 1'b1;
            end else begin
                occ_next_s = occ - ONE;
                ev_acc     = 1'b1;
            end
        end
    end

    // Derived status for the coming cycle, so the registered flags match the counters.
    always_comb begin
        over_next_s = (occ_next_s > cap_next_s);
        if (over_next_s) begin
            free_next_s = ZERO;
        end else begin
            free_next_s = cap_next_s - occ_next_s;
        end
    end

    // Zone state registers.
    always_ff @(posedge clk) begin
        if (start) begin
            cap       <= CAP_NIGHT;
            occ       <= ZERO;
            free      <= CAP_NIGHT;
            has_space <= (CAP_NIGHT != ZERO);
            over_cap  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cap       <= cap_next_s;
            occ       <= occ_next_s;
            free      <= free_next_s;
            has_space <= (free_next_s != ZERO);
            over_cap  <= over_next_s;
            overflow  <= over_next_s & ~over_cap;
        end
    end

endmodule

// File: rtl/parking_zone_ctrl.sv
// Multi-zone parking occupancy controller with hourly capacity schedule.
// Optional per-zone reject and total accept statistics when PARKING_STATS_EN is defined.
module parking_zone_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_ZONES  = 2,
    parameter int CNT_W      = 10,
    parameter int HOUR_W     = 5,
    parameter int OPEN_HOUR  = 8,
    parameter int RAMP_START = 13,
    parameter int RAMP_END   = 16,
    parameter logic [NUM_ZONES*CNT_W-1:0] CAP_DAY   = {10'd200, 10'd500},
    parameter logic [NUM_ZONES*CNT_W-1:0] CAP_NIGHT = {10'd500, 10'd200},
    parameter logic [NUM_ZONES*CNT_W-1:0] CAP_STEP  = {10'sd50, -10'sd50}
) (
    input  logic                              CLK,
    input  logic                              Start,
    input  logic [HOUR_W-1:0]                 hour,
    input  logic                              ev_valid,
    input  logic [zone_idx_w(NUM_ZONES)-1:0]  ev_zone,
    input  logic                              ev_enter,
    output logic                              ev_accept,
    output logic                              ev_reject,
    output logic                              ev_bad_zone,
    output logic [NUM_ZONES*CNT_W-1:0]        occupancy,
    output logic [NUM_ZONES*CNT_W-1:0]        capacity,
    output logic [NUM_ZONES*CNT_W-1:0]        free_space,
    output logic [NUM_ZONES-1:0]              has_space,
    output logic [NUM_ZONES-1:0]              over_cap,
    output logic [NUM_ZONES-1:0]              overflow
`ifdef PARKING_STATS_EN
    ,
    output logic [NUM_ZONES*16-1:0]           rej_count,
    output logic [15:0]                       acc_total
`endif
);

    localparam int ZW = zone_idx_w(NUM_ZONES);

    logic [HOUR_W-1:0]    last_hour_r;
    logic                 tick_s;
    logic                 bad_zone_s;
    logic [NUM_ZONES-1:0] hit_s;
    logic [NUM_ZONES-1:0] acc_s;
    logic [NUM_ZONES-1:0] rej_s;

    assign tick_s     = (hour != last_hour_r);
    assign bad_zone_s = ev_valid && ({1'b0, ev_zone} >= (ZW + 1)'(NUM_ZONES));

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        assign hit_s[z] = ev_valid && (ev_zone == ZW'(z));

        parking_zone_slot #(
            .CNT_W      (CNT_W),
            .HOUR_W     (HOUR_W),
            .OPEN_HOUR  (OPEN_HOUR),
            .RAMP_START (RAMP_START),
            .RAMP_END   (RAMP_END),
            .CAP_DAY    (CAP_DAY[z*CNT_W +: CNT_W]),
            .CAP_NIGHT  (CAP_NIGHT[z*CNT_W +: CNT_W]),
            .CAP_STEP   (CAP_STEP[z*CNT_W +: CNT_W])
        ) u_slot (
            .clk       (CLK),
            .start     (Start),
            .tick      (tick_s),
            .hour      (hour),
            .ev_hit    (hit_s[z]),
            .ev_enter  (ev_enter),
            .cap       (capacity[z*CNT_W +: CNT_W]),
            .occ       (occupancy[z*CNT_W +: CNT_W]),
            .free      (free_space[z*CNT_W +: CNT_W]),
            .has_space (has_space[z]),
            .over_cap  (over_cap[z]),
            .overflow  (overflow[z]),
            .ev_acc    (acc_s[z]),
            .ev_rej    (rej_s[z])
        );
    end

    // Hour tracking and event result pulses; Start drops any pending event.
    always_ff @(posedge CLK) begin
        if (Start) begin
            last_hour_r <= hour;
            ev_accept   <= 1'b0;
            ev_reject   <= 1'b0;
            ev_bad_zone <= 1'b0;
        end else begin
            last_hour_r <= hour;
            ev_accept   <= |acc_s;
            ev_reject   <= (|rej_s) | bad_zone_s;
            ev_bad_zone <= bad_zone_s;
        end
    end

`ifdef PARKING_STATS_EN
    // Saturating statistics; bad-zone rejects are not attributed to any zone.
    always_ff @(posedge CLK) begin
        if (Start) begin
            rej_count <= '0;
            acc_total <= 16'd0;
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (rej_s[z]) begin
                    rej_count[z*16 +: 16] <= sat_inc16(rej_count[z*16 +: 16]);
                end
            end
            if (|acc_s) begin
                acc_total <= sat_inc16(acc_total);
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Directed self-checking bench for parking_zone_ctrl (two-zone default plus a three-zone instance).
module tb_parking_zone_ctrl;

    logic        CLK = 1'b0;
    logic        Start;
    logic [4:0]  hour;
    logic        ev_valid, ev_zone, ev_enter;
    logic        ev_accept, ev_reject, ev_bad_zone;
    logic [19:0] occupancy, capacity, free_space;
    logic [1:0]  has_space, over_cap, overflow;

    logic        ev3_valid, ev3_enter;
    logic [1:0]  ev3_zone;
    logic        ev3_accept, ev3_reject, ev3_bad_zone;
    logic [29:0] occupancy3, capacity3, free_space3;
    logic [2:0]  has_space3, over_cap3, overflow3;

`ifdef PARKING_STATS_EN
    logic [31:0] rej_count;
    logic [15:0] acc_total;
    logic [47:0] rej_count3;
    logic [15:0] acc_total3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    parking_zone_ctrl u_dut (
        .CLK(CLK), .Start(Start), .hour(hour),
        .ev_valid(ev_valid), .ev_zone(ev_zone), .ev_enter(ev_enter),
        .ev_accept(ev_accept), .ev_reject(ev_reject), .ev_bad_zone(ev_bad_zone),
        .occupancy(occupancy), .capacity(capacity), .free_space(free_space),
        .has_space(has_space), .over_cap(over_cap), .overflow(overflow)
`ifdef PARKING_STATS_EN
        , .rej_count(rej_count), .acc_total(acc_total)
`endif
    );

    parking_zone_ctrl #(
        .NUM_ZONES (3),
        .CAP_DAY   ({10'd30, 10'd20, 10'd10}),
        .CAP_NIGHT ({10'd30, 10'd20, 10'd10}),
        .CAP_STEP  (30'd0)
    ) u_dut3 (
        .CLK(CLK), .Start(Start), .hour(hour),
        .ev_valid(ev3_valid), .ev_zone(ev3_zone), .ev_enter(ev3_enter),
        .ev_accept(ev3_accept), .ev_reject(ev3_reject), .ev_bad_zone(ev3_bad_zone),
        .occupancy(occupancy3), .capacity(capacity3), .free_space(free_space3),
        .has_space(has_space3), .over_cap(over_cap3), .overflow(overflow3)
`ifdef PARKING_STATS_EN
        , .rej_count(rej_count3), .acc_total(acc_total3)
`endif
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic z, input logic e);
        ev_valid = v;
        ev_zone  = z;
        ev_enter = e;
    endtask

    task automatic test_reset();
        Start = 1'b1; hour = 5'd0; drive(1'b0, 1'b0, 1'b0);
        ev3_valid = 1'b0; ev3_zone = 2'd0; ev3_enter = 1'b0;
        cyc();
        n_checks++; if (capacity !== {10'd500, 10'd200}) begin n_fail++; $display("FAIL reset_capacity got=%h want=%h", capacity, {10'd500, 10'd200}); end
        n_checks++; if (occupancy !== 20'd0) begin n_fail++; $display("FAIL reset_occupancy got=%h want=0", occupancy); end
        n_checks++; if (free_space !== {10'd500, 10'd200}) begin n_fail++; $display("FAIL reset_free got=%h want=%h", free_space, {10'd500, 10'd200}); end
        n_checks++; if (has_space !== 2'b11) begin n_fail++; $display("FAIL reset_has_space got=%b want=11", has_space); end
        n_checks++; if ({ev_accept, ev_reject, ev_bad_zone, over_cap, overflow} !== 7'd0) begin n_fail++; $display("FAIL reset_flags got=%b want=0", {ev_accept, ev_reject, ev_bad_zone, over_cap, overflow}); end
        Start = 1'b0;
        cyc();
    endtask

    task automatic test_fill_zone0();
        int acc_cnt = 0;
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (ev_accept === 1'b1 && ev_reject === 1'b0) acc_cnt++;
        end
        n_checks++; if (acc_cnt != 200) begin n_fail++; $display("FAIL fill_accepts got=%0d want=200", acc_cnt); end
        n_checks++; if (occupancy[9:0] !== 10'd200) begin n_fail++; $display("FAIL fill_occ got=%0d want=200", occupancy[9:0]); end
        n_checks++; if ({free_space[9:0], has_space} !== {10'd0, 2'b10}) begin n_fail++; $display("FAIL fill_free got=%0d/%b want=0/10", free_space[9:0], has_space); end
        cyc();
        n_checks++; if ({ev_accept, ev_reject} !== 2'b01) begin n_fail++; $display("FAIL full_reject got=%b want=01", {ev_accept, ev_reject}); end
        n_checks++; if (occupancy[9:0] !== 10'd200) begin n_fail++; $display("FAIL full_occ got=%0d want=200", occupancy[9:0]); end
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        n_checks++; if ({ev_accept, ev_reject, ev_bad_zone} !== 3'b000) begin n_fail++; $display("FAIL idle_pulses got=%b want=000", {ev_accept, ev_reject, ev_bad_zone}); end
    endtask

    task automatic test_exit_empty();
        drive(1'b1, 1'b1, 1'b0);
        cyc();
        n_checks++; if ({ev_accept, ev_reject} !== 2'b01 || occupancy[19:10] !== 10'd0) begin n_fail++; $display("FAIL exit_empty got=%b occ=%0d want=01 occ=0", {ev_accept, ev_reject}, occupancy[19:10]); end
        drive(1'b1, 1'b1, 1'b1);
        repeat (300) cyc();
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        n_checks++; if (occupancy !== {10'd300, 10'd200}) begin n_fail++; $display("FAIL fill_zone1 got=%h want=%h", occupancy, {10'd300, 10'd200}); end
    endtask

    task automatic test_schedule();
        hour = 5'd8;
        cyc();
        n_checks++; if (capacity !== {10'd200, 10'd500}) begin n_fail++; $display("FAIL h8_cap got=%h want=%h", capacity, {10'd200, 10'd500}); end
        n_checks++; if ({over_cap, overflow} !== 4'b1010) begin n_fail++; $display("FAIL h8_over got=%b want=1010", {over_cap, overflow}); end
        n_checks++; if (free_space !== {10'd0, 10'd300}) begin n_fail++; $display("FAIL h8_free got=%h want=%h", free_space, {10'd0, 10'd300}); end
        cyc();
        n_checks++; if ({over_cap, overflow} !== 4'b1000) begin n_fail++; $display("FAIL h8_hold got=%b want=1000", {over_cap, overflow}); end
        drive(1'b1, 1'b1, 1'b1);
        cyc();
        n_checks++; if ({ev_accept, ev_reject} !== 2'b01) begin n_fail++; $display("FAIL over_enter got=%b want=01", {ev_accept, ev_reject}); end
        drive(1'b1, 1'b1, 1'b0);
        cyc();
        n_checks++; if (ev_accept !== 1'b1 || occupancy[19:10] !== 10'd299) begin n_fail++; $display("FAIL over_exit got=%b occ=%0d want=1 occ=299", ev_accept, occupancy[19:10]); end
        drive(1'b0, 1'b0, 1'b0);
        hour = 5'd13;
        cyc();
        n_checks++; if (capacity !== {10'd250, 10'd450}) begin n_fail++; $display("FAIL h13_cap got=%h want=%h", capacity, {10'd250, 10'd450}); end
        n_checks++; if ({over_cap, overflow} !== 4'b1000) begin n_fail++; $display("FAIL h13_no_refire got=%b want=1000", {over_cap, overflow}); end
        hour = 5'd14;
        cyc();
        n_checks++; if (capacity !== {10'd300, 10'd400}) begin n_fail++; $display("FAIL h14_cap got=%h want=%h", capacity, {10'd300, 10'd400}); end
        n_checks++; if ({over_cap, free_space, has_space} !== {2'b00, 10'd1, 10'd200, 2'b11}) begin n_fail++; $display("FAIL h14_status got=%b %h %b want=00 %h 11", over_cap, free_space, has_space, {10'd1, 10'd200}); end
    endtask

    task automatic test_tick_event();
        drive(1'b1, 1'b1, 1'b1);
        cyc();
        n_checks++; if (ev_accept !== 1'b1 || has_space !== 2'b01) begin n_fail++; $display("FAIL z1_to_full got=%b hs=%b want=1 hs=01", ev_accept, has_space); end
        hour = 5'd15;
        cyc();
        n_checks++; if ({ev_accept, ev_reject} !== 2'b10) begin n_fail++; $display("FAIL tick_enter got=%b want=10", {ev_accept, ev_reject}); end
        n_checks++; if ({capacity, occupancy} !== {10'd350, 10'd350, 10'd301, 10'd200}) begin n_fail++; $display("FAIL tick_state got=%h %h want=%h %h", capacity, occupancy, {10'd350, 10'd350}, {10'd301, 10'd200}); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_night_and_jump();
        hour = 5'd16;
        cyc();
        n_checks++; if ({capacity, free_space, has_space} !== {10'd500, 10'd200, 10'd199, 10'd0, 2'b10}) begin n_fail++; $display("FAIL h16 got=%h %h %b", capacity, free_space, has_space); end
        hour = 5'd23;
        cyc();
        hour = 5'd0;
        cyc();
        n_checks++; if (capacity !== {10'd500, 10'd200}) begin n_fail++; $display("FAIL wrap_cap got=%h want=%h", capacity, {10'd500, 10'd200}); end
        hour = 5'd14;
        cyc();
        n_checks++; if (capacity !== {10'd550, 10'd150}) begin n_fail++; $display("FAIL jump_cap got=%h want=%h", capacity, {10'd550, 10'd150}); end
        n_checks++; if ({over_cap, overflow, free_space} !== {2'b01, 2'b01, 10'd249, 10'd0}) begin n_fail++; $display("FAIL jump_over got=%b %b %h", over_cap, overflow, free_space); end
        drive(1'b1, 1'b0, 1'b0);
        repeat (49) cyc();
        n_checks++; if (over_cap !== 2'b01 || occupancy[9:0] !== 10'd151) begin n_fail++; $display("FAIL exits49 got=%b occ=%0d want=01 occ=151", over_cap, occupancy[9:0]); end
        cyc();
        n_checks++; if ({over_cap, occupancy[9:0], free_space[9:0]} !== {2'b00, 10'd150, 10'd0}) begin n_fail++; $display("FAIL exits50 got=%b occ=%0d free=%0d", over_cap, occupancy[9:0], free_space[9:0]); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_mid();
        drive(1'b1, 1'b0, 1'b1);
        Start = 1'b1;
        cyc();
        n_checks++; if ({ev_accept, ev_reject, ev_bad_zone} !== 3'b000) begin n_fail++; $display("FAIL start_pulse got=%b want=000", {ev_accept, ev_reject, ev_bad_zone}); end
        n_checks++; if ({occupancy, capacity} !== {20'd0, 10'd500, 10'd200}) begin n_fail++; $display("FAIL start_state got=%h %h", occupancy, capacity); end
        Start = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        n_checks++; if (capacity !== {10'd500, 10'd200}) begin n_fail++; $display("FAIL start_no_tick got=%h want=%h", capacity, {10'd500, 10'd200}); end
    endtask

    task automatic test_bad_zone();
        ev3_valid = 1'b1; ev3_zone = 2'd2; ev3_enter = 1'b1;
        cyc();
        n_checks++; if (ev3_accept !== 1'b1 || occupancy3 !== {10'd1, 10'd0, 10'd0}) begin n_fail++; $display("FAIL z2_enter got=%b occ=%h", ev3_accept, occupancy3); end
        ev3_zone = 2'd3;
        cyc();
        n_checks++; if ({ev3_bad_zone, ev3_reject, ev3_accept} !== 3'b110) begin n_fail++; $display("FAIL bad_zone got=%b want=110", {ev3_bad_zone, ev3_reject, ev3_accept}); end
        n_checks++; if (occupancy3 !== {10'd1, 10'd0, 10'd0}) begin n_fail++; $display("FAIL bad_zone_occ got=%h", occupancy3); end
        ev3_valid = 1'b0;
        cyc();
        n_checks++; if ({ev3_bad_zone, ev3_reject, ev3_accept} !== 3'b000) begin n_fail++; $display("FAIL bad_zone_clear got=%b want=000", {ev3_bad_zone, ev3_reject, ev3_accept}); end
    endtask

`ifdef PARKING_STATS_EN
    task automatic test_stats();
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) cyc();
        drive(1'b1, 1'b1, 1'b0);
        repeat (70000) cyc();
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        n_checks++; if (rej_count !== {16'hFFFF, 16'd0}) begin n_fail++; $display("FAIL rej_sat got=%h want=ffff0000", rej_count); end
        n_checks++; if (acc_total !== 16'd3) begin n_fail++; $display("FAIL acc_total got=%0d want=3", acc_total); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_zone0();
        test_exit_empty();
        test_schedule();
        test_tick_event();
        test_night_and_jump();
        test_start_mid();
`ifdef PARKING_STATS_EN
        test_stats();
`endif
        test_bad_zone();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
